// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: trap/branch/jump redirects,
// stall hold with a pending-redirect buffer. Optional macro: PC_MISALIGN_TRAP_EN.
module pc_gen #(
   parameter int               XLEN         = 32,
   parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
   parameter int               INC          = 4
) (
   input  logic            clk_i,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            trap_i,
   input  logic [XLEN-1:0] trap_vector_i,
   input  logic            br_redirect_i,
   input  logic [XLEN-1:0] br_target_i,
   input  logic            jmp_redirect_i,
   input  logic [XLEN-1:0] jmp_target_i,
   output logic [XLEN-1:0] pc_o,
   output logic            pc_valid_o,
   output logic            redirect_pending_o,
   output logic            misalign_o
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            valid_q, valid_d;
   logic [XLEN-1:0] tgt_q, tgt_d;
   logic            tbr_q, tbr_d;

   logic            redir;
   logic [XLEN-1:0] sel_tgt;
   logic            take_en;
   logic [XLEN-1:0] take_tgt;

   function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

   assign redir   = br_redirect_i | jmp_redirect_i;
   assign sel_tgt = br_redirect_i ? br_target_i : jmp_target_i;

`ifdef PC_MISALIGN_TRAP_EN
   logic mis_q, mis_d;
`endif

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      valid_d  = valid_q;
      tgt_d    = tgt_q;
      tbr_d    = tbr_q;
      take_en  = 1'b0;
      take_tgt = '0;
`ifdef PC_MISALIGN_TRAP_EN
      mis_d    = 1'b0;
`endif
      unique case (state_q)
         BOOT: begin
            valid_d = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            if (trap_i) begin
               pc_d  = align(trap_vector_i);
               tgt_d = '0;
               tbr_d = 1'b0;
            end else if (redir && stall_i) begin
               tgt_d   = sel_tgt;
               tbr_d   = br_redirect_i;
               state_d = HOLD;
            end else if (redir) begin
               take_en  = 1'b1;
               take_tgt = sel_tgt;
            end else if (!stall_i) begin
               pc_d = pc_q + XLEN'(INC);
            end
         end
         HOLD: begin
            if (trap_i) begin
               pc_d    = align(trap_vector_i);
               tgt_d   = '0;
               tbr_d   = 1'b0;
               state_d = RUN;
            end else if (stall_i) begin
               // br always wins; a jmp never displaces a buffered br
               if (br_redirect_i) begin
                  tgt_d = br_target_i;
                  tbr_d = 1'b1;
               end else if (jmp_redirect_i && !tbr_q) begin
                  tgt_d = jmp_target_i;
               end
            end else begin
               take_en  = 1'b1;
               take_tgt = redir ? sel_tgt : tgt_q;
               tgt_d    = '0;
               tbr_d    = 1'b0;
               state_d  = RUN;
            end
         end
         default: state_d = BOOT;
      endcase

      if (take_en) begin
`ifdef PC_MISALIGN_TRAP_EN
         if (|take_tgt[1:0]) begin
            mis_d = 1'b1;
         end else begin
            pc_d = take_tgt;
         end
`else
         pc_d = align(take_tgt);
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
         valid_q <= 1'b0;
         tgt_q   <= '0;
         tbr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         tgt_q   <= tgt_d;
         tbr_q   <= tbr_d;
      end
   end

`ifdef PC_MISALIGN_TRAP_EN
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         mis_q <= 1'b0;
      end else begin
         mis_q <= mis_d;
      end
   end

   assign misalign_o = mis_q;
`else
   assign misalign_o = 1'b0;
`endif

   assign pc_o               = pc_q;
   assign pc_valid_o         = valid_q;
   assign redirect_pending_o = (state_q == HOLD);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with RESET_VECTOR = 32'h1000.
// Expected values are hand-computed; misalign cases follow PC_MISALIGN_TRAP_EN.
module tb_pc_gen;

   logic        clk_i = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_i = 1'b0;
   logic        trap_i = 1'b0;
   logic [31:0] trap_vector_i = '0;
   logic        br_redirect_i = 1'b0;
   logic [31:0] br_target_i = '0;
   logic        jmp_redirect_i = 1'b0;
   logic [31:0] jmp_target_i = '0;
   logic [31:0] pc_o;
   logic        pc_valid_o;
   logic        redirect_pending_o;
   logic        misalign_o;

   int n_chk  = 0;
   int n_pass = 0;

   pc_gen #(
      .XLEN(32),
      .RESET_VECTOR(32'h0000_1000),
      .INC(4)
   ) dut (
      .clk_i(clk_i),
      .rst_n(rst_n),
      .stall_i(stall_i),
      .trap_i(trap_i),
      .trap_vector_i(trap_vector_i),
      .br_redirect_i(br_redirect_i),
      .br_target_i(br_target_i),
      .jmp_redirect_i(jmp_redirect_i),
      .jmp_target_i(jmp_target_i),
      .pc_o(pc_o),
      .pc_valid_o(pc_valid_o),
      .redirect_pending_o(redirect_pending_o),
      .misalign_o(misalign_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic st, input logic tr, input logic [31:0] tv,
                        input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt);
      stall_i        = st;
      trap_i         = tr;
      trap_vector_i  = tv;
      br_redirect_i  = br;
      br_target_i    = bt;
      jmp_redirect_i = jp;
      jmp_target_i   = jt;
   endtask

   task automatic idle();
      drive(0, 0, '0, 0, '0, 0, '0);
   endtask

   initial begin
      idle();
      #12;
      chk("rst_pc", pc_o, 32'h1000);
      chk("rst_valid", {31'd0, pc_valid_o}, 32'd0);
      chk("rst_pend", {31'd0, redirect_pending_o}, 32'd0);
      chk("rst_mis", {31'd0, misalign_o}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_pc", pc_o, 32'h1000);
      chk("rel_valid", {31'd0, pc_valid_o}, 32'd0);

      // boot edge ignores a redirect
      drive(0, 0, '0, 1, 32'h0000_0900, 0, '0);
      step();
      chk("boot_pc", pc_o, 32'h1000);
      chk("boot_valid", {31'd0, pc_valid_o}, 32'd1);
      idle();
      step();
      chk("seq1", pc_o, 32'h1004);
      step();
      chk("seq2", pc_o, 32'h1008);

      drive(0, 0, '0, 0, '0, 1, 32'h40);
      step();
      chk("jmp40", pc_o, 32'h40);

      drive(0, 1, 32'h100, 1, 32'h200, 1, 32'h300);
      step();
      chk("prio_trap", pc_o, 32'h100);

      drive(0, 0, '0, 1, 32'h200, 1, 32'h300);
      step();
      chk("prio_br", pc_o, 32'h200);

      drive(1, 0, '0, 0, '0, 0, '0);
      step();
      chk("stall_hold", pc_o, 32'h200);

      drive(0, 0, '0, 0, '0, 1, 32'h80);
      step();
      chk("jmp80", pc_o, 32'h80);

      drive(1, 0, '0, 0, '0, 1, 32'h300);
      step();
      chk("hold_jmp_pc", pc_o, 32'h80);
      chk("hold_jmp_pend", {31'd0, redirect_pending_o}, 32'd1);
      drive(1, 0, '0, 1, 32'h200, 0, '0);
      step();
      chk("hold_br_pc", pc_o, 32'h80);
      chk("hold_valid", {31'd0, pc_valid_o}, 32'd1);
      drive(1, 0, '0, 0, '0, 1, 32'h300);
      step();
      chk("hold_drop_pc", pc_o, 32'h80);
      idle();
      step();
      chk("release_pc", pc_o, 32'h200);
      chk("release_pend", {31'd0, redirect_pending_o}, 32'd0);
      step();
      chk("after_rel", pc_o, 32'h204);

      drive(1, 0, '0, 1, 32'h200, 0, '0);
      step();
      chk("hold2_pend", {31'd0, redirect_pending_o}, 32'd1);
      drive(1, 1, 32'h100, 0, '0, 0, '0);
      step();
      chk("trap_hold_pc", pc_o, 32'h100);
      chk("trap_hold_pend", {31'd0, redirect_pending_o}, 32'd0);
      idle();
      step();
      chk("trap_cleared", pc_o, 32'h104);

      drive(1, 0, '0, 1, 32'h500, 0, '0);
      step();
      drive(0, 0, '0, 0, '0, 1, 32'h600);
      step();
      chk("rel_new_wins", pc_o, 32'h600);

      drive(0, 0, '0, 0, '0, 1, 32'hFFFF_FFFC);
      step();
      chk("top_pc", pc_o, 32'hFFFF_FFFC);
      idle();
      step();
      chk("wrap_pc", pc_o, 32'h0);
      step();
      chk("wrap_next", pc_o, 32'h4);

      drive(0, 0, '0, 1, 32'h202, 0, '0);
      step();
`ifdef PC_MISALIGN_TRAP_EN
      chk("mis_pc", pc_o, 32'h4);
      chk("mis_flag", {31'd0, misalign_o}, 32'd1);
`else
      chk("mis_pc", pc_o, 32'h200);
      chk("mis_flag", {31'd0, misalign_o}, 32'd0);
`endif
      idle();
      step();
`ifdef PC_MISALIGN_TRAP_EN
      chk("mis_next_pc", pc_o, 32'h8);
`else
      chk("mis_next_pc", pc_o, 32'h204);
`endif
      chk("mis_pulse_end", {31'd0, misalign_o}, 32'd0);

      drive(1, 0, '0, 1, 32'h700, 0, '0);
      step();
      chk("pre_rst_pend", {31'd0, redirect_pending_o}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_pc", pc_o, 32'h1000);
      chk("async_pend", {31'd0, redirect_pending_o}, 32'd0);
      chk("async_valid", {31'd0, pc_valid_o}, 32'd0);
      idle();
      #10;
      rst_n = 1'b1;
      step();
      step();
      chk("reboot_pc", pc_o, 32'h1004);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the RISC-V fetch stage. It supersedes the plain PC register.
- Provides:
  - configurable XLEN and reset vector
  - prioritised redirect sources: trap, EX branch, ID jump
  - stall handling, with a pending-redirect buffer so redirects arriving during a stall are not lost
  - a boot state that qualifies the first fetch
- Sits between the hazard unit, EX/ID redirect logic and the instruction-memory address port.

Parameters:
- XLEN, 32: PC and target width.
- RESET_VECTOR, 0: pc_o value on reset.
- INC, 4: sequential increment in bytes.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  hold PC (load-use or other hazard).
- trap_i  input  1  trap/exception redirect request.
- trap_vector_i  input  XLEN  trap target.
- br_redirect_i  input  1  EX-stage branch/mispredict redirect.
- br_target_i  input  XLEN  EX redirect target.
- jmp_redirect_i  input  1  ID-stage jump redirect.
- jmp_target_i  input  XLEN  ID jump target.
- pc_o  output  XLEN  current fetch address.
- pc_valid_o  output  1  pc_o is a valid fetch request.
- redirect_pending_o  output  1  a redirect is buffered during a stall.
- misalign_o  output  1  misaligned redirect flag (see Optional Feature).

Behaviour:
- Clock and reset: single clock clk_i; reset rst_n is asynchronous, active-low.
- Reset values:
  - pc_o = RESET_VECTOR
  - pc_valid_o = 0
  - redirect_pending_o = 0
  - misalign_o = 0
  - pending target = 0
  - state = BOOT
  - Reset asserted mid-operation discards any pending redirect immediately.
- State BOOT:
  - First rising edge after reset release: pc_o stays RESET_VECTOR, pc_valid_o <= 1, state -> RUN.
  - All redirect and stall inputs are ignored in BOOT.
- State RUN, next pc_o selected by priority:
  1. trap_i: trap_vector_i
  2. br_redirect_i: br_target_i
  3. jmp_redirect_i: jmp_target_i
  4. stall_i: hold
  5. otherwise: pc_o + INC, modulo 2^XLEN (all-ones region wraps to 0, no flag)
- Trap bypasses stall:
  - trap_i loads trap_vector_i even when stall_i = 1.
  - It clears any pending redirect and stays in or returns to RUN.
- Redirect during stall:
  - br or jmp with stall_i = 1 and no trap: pc_o holds, the target is latched into the pending register, redirect_pending_o <= 1, state -> HOLD.
- State HOLD:
  - pc_o holds while stall_i = 1.
  - Each new br/jmp overwrites the pending target if its priority is greater than or equal to the buffered one; br outranks jmp.
  - A jmp arriving after a buffered br is dropped.
  - When stall_i = 0:
    - A simultaneous new br/jmp takes precedence over the pending target.
    - Otherwise pc_o <= pending target.
    - redirect_pending_o <= 0, state -> RUN.
  - trap_i in HOLD: load trap_vector_i, clear pending, state -> RUN.
- Latency and validity:
  - One cycle from any input to pc_o.
  - pc_valid_o stays 1 in RUN and HOLD; the stall is signalled to fetch by the hazard unit, not by pc_valid_o.
- Target alignment: targets with bits [1:0] != 0 are loaded with bits [1:0] forced to 0; misalign_o is tied to 0.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - A selected redirect (trap excluded) whose target has bits [1:0] != 0 is not taken; pc_o holds.
  - misalign_o pulses 1 for exactly one cycle, registered.
  - Any pending redirect is cleared.
  - The trap unit is expected to respond with trap_i.
  - In HOLD, a misaligned pending target is checked on release with the same rule.
- Undefined: alignment bits are forced to 0 as above; misalign_o is constant 0.

Test Plan:
- Reset and boot, RESET_VECTOR = 32'h0000_1000: release rst_n -> pc_o = 32'h1000 with pc_valid_o = 0, then pc_valid_o = 1 at 32'h1000, then 32'h1004, 32'h1008.
- Priority: from pc_o = 32'h40, assert trap (32'h100), br (32'h200) and jmp (32'h300) in the same cycle -> next pc_o = 32'h100. Br + jmp only -> 32'h200.
- Stall with buffered redirect: stall_i = 1 at pc_o = 32'h80; jmp to 32'h300, then br to 32'h200 during the stall -> pc_o stays 32'h80 and redirect_pending_o = 1. Drop stall -> pc_o = 32'h200, redirect_pending_o = 0, then 32'h204.
- Trap during stall: in HOLD with pending 32'h200, trap_i to 32'h100 -> pc_o = 32'h100 on the next edge and the pending redirect is cleared.
- Wrap and async reset: pc_o = 32'hFFFF_FFFC with no stall -> 32'h0. Assert rst_n low mid-cycle while in HOLD -> pc_o = RESET_VECTOR and redirect_pending_o = 0 immediately, without waiting for an edge.
- Misalignment: br to 32'h202 -> without the macro, pc_o = 32'h200 and misalign_o = 0; with PC_MISALIGN_TRAP_EN, pc_o holds and misalign_o = 1 for one cycle.
